du_fsmplusd_param: RTL and testbench

- Parametrised next-generation datapath unit for FSM+D controllers: three WIDTH-bit registers R1/R2/R3 with per-register source-select muxes and load enables.
- Replaces the single-cycle multiply with an iterative shift-add multiplier that uses a busy/done handshake.
- Adds a sticky overflow flag.
- Defines every mux code; no don't-care loads.
- Driven by an external control FSM, which polls busy and done.

---
 rtl/du_fsmplusd_param_if.sv | 28 ++
 rtl/du_fsmplusd_param.sv | 169 ++++++++++++++++
 tb/tb_du_fsmplusd_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/du_fsmplusd_param_if.sv
// Operand, select, load and status bundle between a control FSM
// and the FSM+D datapath unit.
interface du_fsmplusd_param_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a, b, c, d, e;
  logic [1:0]       sel1, sel2, sel3;
  logic             ldR1, ldR2, ldR3;
  logic             clr_ovf;
  logic [WIDTH-1:0] R1, R2, R3;
  logic             busy, done, ovf, mul_conflict;

  modport master (
    output a, b, c, d, e,
    output sel1, sel2, sel3,
    output ldR1, ldR2, ldR3, clr_ovf,
    input  R1, R2, R3,
    input  busy, done, ovf, mul_conflict
  );

  modport slave (
    input  a, b, c, d, e,
    input  sel1, sel2, sel3,
    input  ldR1, ldR2, ldR3, clr_ovf,
    output R1, R2, R3,
    output busy, done, ovf, mul_conflict
  );
endinterface

// File: rtl/du_fsmplusd_param.sv
// Three-register FSM+D datapath with iterative shift-add multiply.
// DU_SAT_EN: saturate overflowing results to all-ones instead of wrapping.
module du_fsmplusd_param #(
  parameter int WIDTH = 4
) (
  input logic clock,
  input logic reset,
  du_fsmplusd_param_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam int CW = $clog2(WIDTH + 1);
`ifdef DU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [2*WIDTH-1:0] dword_t;

  logic [0:0]    state_q, state_d;
  word_t         r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  dword_t        mcand_q, mcand_d, acc_q, acc_d;
  word_t         mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dst_q, dst_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          conf_q, conf_d;
  logic          ovf_set, mul1, last;
  logic [WIDTH:0] sum13, sum12, sum23;
  dword_t        acc_nx;

  function automatic word_t fit(input logic ov, input word_t v);
    return (SAT && ov) ? '1 : v;
  endfunction

  assign sum13  = {1'b0, r1_q} + {1'b0, r3_q};
  assign sum12  = {1'b0, r1_q} + {1'b0, r2_q};
  assign sum23  = {1'b0, r2_q} + {1'b0, r3_q};
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign mul1   = bus.ldR1 && (bus.sel1 == 2'd0);

  always_comb begin
    state_d  = state_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    done_d   = 1'b0;
    conf_d   = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ldR1) begin
          unique case (bus.sel1)
            2'd0: begin
              state_d  = MUL;
              mcand_d  = {{WIDTH{1'b0}}, r1_q};
              mplier_d = r3_q;
              acc_d    = '0;
              cnt_d    = '0;
              dst_d    = 1'b0;
            end
            2'd1: begin
              r1_d    = fit(sum13[WIDTH], sum13[WIDTH-1:0]);
              ovf_set = sum13[WIDTH];
            end
            2'd2: begin
              r1_d    = fit(sum12[WIDTH], sum12[WIDTH-1:0]);
              ovf_set = sum12[WIDTH];
            end
            2'd3: r1_d = bus.a;
          endcase
        end
        if (bus.ldR2) begin
          unique case (bus.sel2)
            2'd0: begin
              // R1 owns the multiplier when both ask in one cycle
              if (mul1) begin
                conf_d = 1'b1;
              end else begin
                state_d  = MUL;
                mcand_d  = {{WIDTH{1'b0}}, r1_q};
                mplier_d = r2_q;
                acc_d    = '0;
                cnt_d    = '0;
                dst_d    = 1'b1;
              end
            end
            2'd1: begin
              r2_d    = fit(sum23[WIDTH], sum23[WIDTH-1:0]);
              ovf_set = ovf_set | sum23[WIDTH];
            end
            2'd2: r2_d = bus.c;
            2'd3: r2_d = r2_q;
          endcase
        end
        if (bus.ldR3) begin
          unique case (bus.sel3)
            2'd0: r3_d = bus.e;
            2'd1: r3_d = bus.d;
            2'd2: r3_d = bus.b;
            2'd3: r3_d = r3_q;
          endcase
        end
      end
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ovf_set = |acc_nx[2*WIDTH-1:WIDTH];
          if (dst_q) r2_d = fit(ovf_set, acc_nx[WIDTH-1:0]);
          else       r1_d = fit(ovf_set, acc_nx[WIDTH-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_set | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      r1_q     <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dst_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      conf_q   <= conf_d;
    end
  end

  assign bus.R1           = r1_q;
  assign bus.R2           = r2_q;
  assign bus.R3           = r3_q;
  assign bus.busy         = (state_q == MUL);
  assign bus.done         = done_q;
  assign bus.ovf          = ovf_q;
  assign bus.mul_conflict = conf_q;
endmodule

// File: tb/tb_du_fsmplusd_param.sv
// Scoreboard bench: stimulus pushes model predictions, monitor pops
// and compares every cycle after the clock edge.
module tb_du_fsmplusd_param;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  du_fsmplusd_param_if #(.WIDTH(W)) bus ();

  du_fsmplusd_param #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] r1, r2, r3;
    logic busy, done, ovf, conf;
  } exp_t;

  typedef struct packed {
    logic l1, l2, l3;
    logic [1:0] s1, s2, s3;
    logic [W-1:0] a, b, c, d, e;
    logic clr;
  } in_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_r1, m_r2, m_r3, m_left, m_dst, m_prod;
  bit m_ovf;

  function automatic int fit(int v);
`ifdef DU_SAT_EN
    return (v > MASK) ? MASK : v;
`else
    return v & MASK;
`endif
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s = {bus.R1, bus.R2, bus.R3, bus.busy, bus.done, bus.ovf,
         bus.mul_conflict};
    return s;
  endfunction

  task automatic cmp(string nm, exp_t got, exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got r1=%0d r2=%0d r3=%0d busy=%b done=%b ovf=%b conf=%b, expected r1=%0d r2=%0d r3=%0d busy=%b done=%b ovf=%b conf=%b",
        nm, got.r1, got.r2, got.r3, got.busy, got.done, got.ovf, got.conf,
        want.r1, want.r2, want.r3, want.busy, want.done, want.ovf, want.conf);
    end
  endtask

  function automatic void model_reset();
    m_r1 = 0; m_r2 = 0; m_r3 = 0;
    m_left = 0; m_dst = 0; m_prod = 0; m_ovf = 0;
  endfunction

  function automatic exp_t model_step(in_t i);
    int n1, n2, n3;
    bit set, done, conf;
    exp_t x;
    n1 = m_r1; n2 = m_r2; n3 = m_r3;
    set = 0; done = 0; conf = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        set  = (m_prod > MASK);
        done = 1;
        if (m_dst == 1) n1 = fit(m_prod);
        else            n2 = fit(m_prod);
      end
    end else begin
      if (i.l1) begin
        case (i.s1)
          0: begin m_prod = m_r1 * m_r3; m_dst = 1; m_left = W; end
          1: begin n1 = fit(m_r1 + m_r3); set |= (m_r1 + m_r3 > MASK); end
          2: begin n1 = fit(m_r1 + m_r2); set |= (m_r1 + m_r2 > MASK); end
          default: n1 = int'(i.a);
        endcase
      end
      if (i.l2) begin
        case (i.s2)
          0: if (i.l1 && i.s1 == 0) conf = 1;
             else begin m_prod = m_r1 * m_r2; m_dst = 2; m_left = W; end
          1: begin n2 = fit(m_r2 + m_r3); set |= (m_r2 + m_r3 > MASK); end
          2: n2 = int'(i.c);
          default: ;
        endcase
      end
      if (i.l3) begin
        case (i.s3)
          0: n3 = int'(i.e);
          1: n3 = int'(i.d);
          2: n3 = int'(i.b);
          default: ;
        endcase
      end
    end
    m_ovf = set | (m_ovf & !i.clr);
    m_r1 = n1; m_r2 = n2; m_r3 = n3;
    x.r1 = W'(m_r1); x.r2 = W'(m_r2); x.r3 = W'(m_r3);
    x.busy = (m_left > 0); x.done = done; x.ovf = m_ovf; x.conf = conf;
    return x;
  endfunction

  function automatic in_t mk(bit l1, int s1, bit l2, int s2, bit l3, int s3,
                             int a, int c, int d, bit clr);
    in_t i;
    i = '0;
    i.l1 = l1; i.s1 = 2'(s1);
    i.l2 = l2; i.s2 = 2'(s2);
    i.l3 = l3; i.s3 = 2'(s3);
    i.a = W'(a); i.c = W'(c); i.d = W'(d);
    i.clr = clr;
    return i;
  endfunction

  task automatic drive(in_t i);
    bus.ldR1 = i.l1; bus.ldR2 = i.l2; bus.ldR3 = i.l3;
    bus.sel1 = i.s1; bus.sel2 = i.s2; bus.sel3 = i.s3;
    bus.a = i.a; bus.b = i.b; bus.c = i.c; bus.d = i.d; bus.e = i.e;
    bus.clr_ovf = i.clr;
  endtask

  task automatic cycle(in_t i);
    @(negedge clock);
    drive(i);
    q.push_back(model_step(i));
    @(posedge clock);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  always @(posedge clock) begin
    #1;
    if (reset && q.size() > 0) cmp("cycle", sample(), q.pop_front());
  end

  initial begin
    in_t r;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clock);
    #1 cmp("reset", sample(), '0);
    @(negedge clock);
    reset = 1'b1;

    cycle(mk(1, 3, 0, 0, 1, 1, 5, 0, 3, 0));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 1, 2, 0, 0, 0, 9, 0, 0));
    cycle(mk(0, 0, 1, 3, 0, 0, 0, 0, 0, 0));

    cycle(mk(1, 3, 0, 0, 0, 0, 5, 0, 0, 0));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 1, 1, 0, 0, 7, 0));
    idle(4);

    cycle(mk(1, 3, 0, 0, 1, 1, 12, 0, 6, 0));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle(mk(1, 3, 0, 0, 0, 0, 12, 0, 0, 0));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));

    cycle(mk(1, 3, 1, 2, 1, 1, 2, 4, 3, 0));
    cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    idle(5);

    cycle(mk(1, 3, 0, 0, 1, 1, 7, 0, 9, 0));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(2);
    @(negedge clock);
    reset = 1'b0;
    #1 cmp("async_reset", sample(), '0);
    q.delete();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(W + 2);

    for (int n = 0; n < 600; n++) begin
      r = '0;
      r.l1 = ($urandom_range(0, 2) == 0);
      r.l2 = ($urandom_range(0, 2) == 0);
      r.l3 = ($urandom_range(0, 2) == 0);
      r.s1 = 2'($urandom_range(0, 3));
      r.s2 = 2'($urandom_range(0, 3));
      r.s3 = 2'($urandom_range(0, 3));
      r.a = W'($urandom); r.b = W'($urandom); r.c = W'($urandom);
      r.d = W'($urandom); r.e = W'($urandom);
      r.clr = ($urandom_range(0, 7) == 0);
      cycle(r);
    end
    idle(W + 1);

    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
